// File: rtl/thumb_pkg.sv
// Shared types and widths for the Thumb fetch front-end.
package thumb_pkg;
    localparam int HWORD_W = 16;
    localparam int WORD_W  = 32;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;
endpackage

// File: rtl/thumb_hword_fifo.sv
// Halfword prefetch queue: up to two pushes and one pop per cycle, synchronous flush.
module thumb_hword_fifo
    import thumb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic [1:0]               push_n,
    input  logic [HWORD_W-1:0]       push_d0,
    input  logic [HWORD_W-1:0]       push_d1,
    input  logic                     pop,
    output logic [HWORD_W-1:0]       head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [HWORD_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push_n);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + (AW+1)'(push_n) - (AW+1)'(pop);
        end
    end

    // Storage carries no reset; entries are only read once counted valid.
    always_ff @(posedge clock) begin
        if (!flush) begin
            if (push_n != 2'd0)
                mem[wr_ptr] <= push_d0;
            if (push_n == 2'd2)
                mem[wr_ptr + AW'(1)] <= push_d1;
        end
    end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/thumb_fetch_unit.sv
// Thumb fetch front-end: word fetch, halfword split, prefetch queue, redirect flush.
// Optional THUMB_FETCH_STATS_EN adds stat_words / stat_flushes counters.
module thumb_fetch_unit
    import thumb_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clock,
    input  logic                reset_n,
    output logic                mem_req,
    output logic [ADDR_W-3:0]   mem_addr,
    input  logic                mem_ack,
    input  logic [WORD_W-1:0]   mem_rdata,
    input  logic                redirect,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic                instr_valid,
    output logic [HWORD_W-1:0]  instr,
    output logic [ADDR_W-1:0]   instr_pc,
    input  logic                instr_ready
`ifdef THUMB_FETCH_STATS_EN
    ,
    output logic [31:0]         stat_words,
    output logic [31:0]         stat_flushes
`endif
);
    localparam int                CW        = $clog2(DEPTH) + 1;
    localparam logic [ADDR_W-1:0] RESET_HPC = RESET_PC & ~ADDR_W'(1);

    fetch_state_t       state, state_nxt;
    logic [ADDR_W-1:0]  fpc, hpc, target;
    logic [ADDR_W-3:0]  req_addr;
    logic [CW-1:0]      count, free, need;
    logic               live, issue, enq, pop;
    logic [1:0]         push_n;
    logic [HWORD_W-1:0] push_d0, push_d1, head;

    // An odd-halfword fetch PC only consumes the upper half of its word.
    always_comb begin
        target    = redirect_pc & ~ADDR_W'(1);
        need      = fpc[1] ? CW'(1) : CW'(2);
        free      = CW'(DEPTH) - count;
        issue     = live && (state == RUN) && (free >= need) && !redirect;
        mem_req   = issue || (state == WAIT) || (state == DRAIN);
        mem_addr  = (state == RUN) ? fpc[ADDR_W-1:2] : req_addr;
        enq       = mem_ack && !redirect && (issue || (state == WAIT));
        push_n    = !enq ? 2'd0 : (fpc[1] ? 2'd1 : 2'd2);
        push_d0   = fpc[1] ? mem_rdata[WORD_W-1:HWORD_W] : mem_rdata[HWORD_W-1:0];
        push_d1   = mem_rdata[WORD_W-1:HWORD_W];
        pop       = instr_valid && instr_ready && !redirect;
        state_nxt = state;
        case (state)
            RUN:     if (issue && !mem_ack) state_nxt = WAIT;
            WAIT: begin
                if (mem_ack)       state_nxt = RUN;
                else if (redirect) state_nxt = DRAIN;
            end
            DRAIN:   if (mem_ack) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // live holds off the first request until the cycle after reset release.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            live  <= 1'b0;
            state <= RUN;
            fpc   <= RESET_HPC;
            hpc   <= RESET_HPC;
        end else begin
            live  <= 1'b1;
            state <= state_nxt;
            if (redirect) begin
                fpc <= target;
                hpc <= target;
            end else begin
                if (enq)
                    fpc <= fpc + (fpc[1] ? ADDR_W'(2) : ADDR_W'(4));
                if (pop)
                    hpc <= hpc + ADDR_W'(2);
            end
        end
    end

    // Outstanding word address, kept through DRAIN after fpc has moved on.
    always_ff @(posedge clock) begin
        if (issue)
            req_addr <= fpc[ADDR_W-1:2];
    end

    thumb_hword_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .flush   (redirect),
        .push_n  (push_n),
        .push_d0 (push_d0),
        .push_d1 (push_d1),
        .pop     (pop),
        .head    (head),
        .count   (count)
    );

    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? head : '0;
    assign instr_pc    = hpc;

`ifdef THUMB_FETCH_STATS_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stat_words   <= '0;
            stat_flushes <= '0;
        end else begin
            if (mem_ack)
                stat_words <= stat_words + 32'd1;
            if (redirect)
                stat_flushes <= stat_flushes + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_thumb_fetch_unit.sv
// Directed-vector bench for thumb_fetch_unit (32-bit and 8-bit address instances).
module tb_thumb_fetch_unit;
    logic        clock;
    logic        reset_n;
    logic        mem_req;
    logic [29:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [15:0] instr;
    logic [31:0] instr_pc;
    logic        ready;

    logic        mem_req8;
    logic [5:0]  mem_addr8;
    logic        mem_ack8;
    logic [31:0] mem_rdata8;
    logic        redirect8;
    logic [7:0]  rpc8;
    logic        instr_valid8;
    logic [15:0] instr8;
    logic [7:0]  instr_pc8;
    logic        ready8;

`ifdef THUMB_FETCH_STATS_EN
    logic [31:0] stat_words, stat_flushes, stat_words8, stat_flushes8;
`endif

    logic [31:0] mem [32];
    int          lat;
    int          mwait;
    int          n_vec;
    int          n_err;

    thumb_fetch_unit #(.ADDR_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (ready)
`ifdef THUMB_FETCH_STATS_EN
        ,
        .stat_words   (stat_words),
        .stat_flushes (stat_flushes)
`endif
    );

    thumb_fetch_unit #(.ADDR_W(8), .DEPTH(4), .RESET_PC(8'h0)) dut8 (
        .clock       (clock),
        .reset_n     (reset_n),
        .mem_req     (mem_req8),
        .mem_addr    (mem_addr8),
        .mem_ack     (mem_ack8),
        .mem_rdata   (mem_rdata8),
        .redirect    (redirect8),
        .redirect_pc (rpc8),
        .instr_valid (instr_valid8),
        .instr       (instr8),
        .instr_pc    (instr_pc8),
        .instr_ready (ready8)
`ifdef THUMB_FETCH_STATS_EN
        ,
        .stat_words   (stat_words8),
        .stat_flushes (stat_flushes8)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory model: ack after lat wait cycles of a held request.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n)                 mwait <= 0;
        else if (!mem_req || mem_ack) mwait <= 0;
        else                          mwait <= mwait + 1;
    end
    assign mem_ack    = mem_req && (mwait >= lat);
    assign mem_rdata  = mem[mem_addr[4:0]];
    assign mem_ack8   = mem_req8;
    assign mem_rdata8 = {16'hC000 | {10'b0, mem_addr8}, 16'hD000 | {10'b0, mem_addr8}};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0; n_err = 0;
        reset_n = 1'b0; redirect = 1'b0; redirect_pc = '0; ready = 1'b1; lat = 0;
        redirect8 = 1'b0; rpc8 = '0; ready8 = 1'b1;
        for (int i = 0; i < 32; i++)
            mem[i] = {16'(16'h9000 + i*4 + 2), 16'(16'h9000 + i*4)};
        mem[0] = 32'h2105_2003;
        mem[1] = 32'hBEEF_1234;
        step(); step();
        chk("rst_req",   32'(mem_req),     32'd0);
        chk("rst_addr",  32'(mem_addr),    32'd0);
        chk("rst_vld",   32'(instr_valid), 32'd0);
        chk("rst_instr", 32'(instr),       32'd0);
        chk("rst_pc",    instr_pc,         32'd0);
        chk("rst_cnt",   32'(dut.count),   32'd0);
        reset_n = 1'b1;

        // Zero-wait streaming from reset
        step();
        chk("b_req",  32'(mem_req),     32'd1);
        chk("b_addr", 32'(mem_addr),    32'd0);
        chk("b_vld",  32'(instr_valid), 32'd0);
        step();
        chk("c_instr", 32'(instr),    32'h2003);
        chk("c_pc",    instr_pc,      32'h0);
        chk("c_addr",  32'(mem_addr), 32'd1);
        chk("c_req",   32'(mem_req),  32'd1);
        step();
        chk("d_instr", 32'(instr),   32'h2105);
        chk("d_pc",    instr_pc,     32'h2);
        chk("d_req",   32'(mem_req), 32'd0);
        step();
        chk("e_instr", 32'(instr), 32'h1234);
        chk("e_pc",    instr_pc,   32'h4);
        step();
        chk("f_instr", 32'(instr), 32'hBEEF);
        chk("f_pc",    instr_pc,   32'h6);

        // Redirect to an odd halfword
        redirect = 1'b1; redirect_pc = 32'h6;
        step(); redirect = 1'b0; #1;
        chk("g_vld",  32'(instr_valid), 32'd0);
        chk("g_pc",   instr_pc,         32'h6);
        chk("g_addr", 32'(mem_addr),    32'd1);
        chk("g_req",  32'(mem_req),     32'd1);
        step();
        chk("h_vld",   32'(instr_valid), 32'd1);
        chk("h_instr", 32'(instr),       32'hBEEF);
        chk("h_pc",    instr_pc,         32'h6);
        chk("h_addr",  32'(mem_addr),    32'd2);
        step();
        chk("i_instr", 32'(instr), 32'h9008);
        chk("i_pc",    instr_pc,   32'h8);

        // Queue fill with decode stalled
        ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h20;
        step(); redirect = 1'b0; #1;
        step(); step();
        chk("full_cnt",   32'(dut.count), 32'd4);
        chk("full_req",   32'(mem_req),   32'd0);
        chk("full_instr", 32'(instr),     32'h9020);
        chk("full_pc",    instr_pc,       32'h20);
        ready = 1'b1;
        step(); ready = 1'b0;
        chk("pop1_cnt",   32'(dut.count), 32'd3);
        chk("pop1_req",   32'(mem_req),   32'd0);
        chk("pop1_instr", 32'(instr),     32'h9022);
        chk("pop1_pc",    instr_pc,       32'h22);
        ready = 1'b1;
        step(); ready = 1'b0;
        chk("pop2_req",  32'(mem_req),  32'd1);
        chk("pop2_addr", 32'(mem_addr), 32'h0A);
        step();

        // Redirect during the first WAIT cycle of a slow request
        lat = 3; redirect = 1'b1; redirect_pc = 32'h30;
        step(); redirect = 1'b0; #1;
        chk("w1_req",  32'(mem_req),  32'd1);
        chk("w1_addr", 32'(mem_addr), 32'h0C);
        step(); redirect = 1'b1; redirect_pc = 32'h40; #1;
        chk("w2_req",  32'(mem_req),  32'd1);
        chk("w2_addr", 32'(mem_addr), 32'h0C);
        step(); redirect = 1'b0; #1;
        chk("dr_addr", 32'(mem_addr),    32'h0C);
        chk("dr_req",  32'(mem_req),     32'd1);
        chk("dr_vld",  32'(instr_valid), 32'd0);
        chk("dr_pc",   instr_pc,         32'h40);
        step();
        chk("dr_ack_addr", 32'(mem_addr), 32'h0C);
        chk("dr_ack",      32'(mem_ack),  32'd1);
        step();
        chk("nx_addr", 32'(mem_addr),    32'h10);
        chk("nx_req",  32'(mem_req),     32'd1);
        chk("nx_vld",  32'(instr_valid), 32'd0);
        step(); step(); step();
        chk("nx_stale", 32'(instr_valid), 32'd0);
        step();
        chk("nx_vld1",  32'(instr_valid), 32'd1);
        chk("nx_instr", 32'(instr),       32'h9040);
        chk("nx_pc",    instr_pc,         32'h40);

        // Redirect, pop and ack landing together
        lat = 1; ready = 1'b1;
        step();
        chk("tri_instr", 32'(instr), 32'h9042);
        chk("tri_pc",    instr_pc,   32'h42);
        redirect = 1'b1; redirect_pc = 32'h80; #1;
        chk("tri_ack", 32'(mem_ack), 32'd1);
        step(); redirect = 1'b0; ready = 1'b0; #1;
        chk("tri_vld",  32'(instr_valid), 32'd0);
        chk("tri_pc2",  instr_pc,         32'h80);
        chk("tri_cnt",  32'(dut.count),   32'd0);
        chk("tri_addr", 32'(mem_addr),    32'h20);
        chk("tri_req",  32'(mem_req),     32'd1);

        // 8-bit address space wrap
        redirect8 = 1'b1; rpc8 = 8'hFE;
        step(); redirect8 = 1'b0; #1;
        chk("w8_addr", 32'(mem_addr8),    32'h3F);
        chk("w8_vld",  32'(instr_valid8), 32'd0);
        chk("w8_pc",   32'(instr_pc8),    32'hFE);
        step();
        chk("w8_vld1",  32'(instr_valid8), 32'd1);
        chk("w8_instr", 32'(instr8),       32'hC03F);
        chk("w8_pc1",   32'(instr_pc8),    32'hFE);
        chk("w8_addr1", 32'(mem_addr8),    32'h00);
        step();
        chk("w8_instr2", 32'(instr8),    32'hD000);
        chk("w8_pc2",    32'(instr_pc8), 32'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
